// File: rtl/pll_rst_pkg.sv
// Shared types and defaults for the PLL supervisor / reset sequencer.
//   state_e : sequencer states
//   DEF_*   : default parameter values
//   RETRY_W : width of the retry counter (saturates at RETRY_MAX)
//   cnt_w() : bits needed to hold a counter's maximum value
package pll_rst_pkg;

    typedef enum logic [2:0] {
        RESET_PLL,
        WAIT_LOCK,
        STABLE,
        RELEASE,
        RUN,
        FAULT
    } state_e;

    localparam int unsigned DEF_NUM_DOMAINS         = 2;
    localparam int unsigned DEF_RST_PULSE_CYCLES    = 16;
    localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 100000;
    localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 1024;
    localparam int unsigned DEF_STAGE_DELAY_CYCLES  = 64;
    localparam int unsigned DEF_MAX_RETRIES         = 7;

    localparam int unsigned RETRY_W   = 4;
    localparam int unsigned RETRY_MAX = (1 << RETRY_W) - 1;

    // Width that holds 0..max_val, never less than one bit.
    function automatic int unsigned cnt_w(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/pll_rst_seq_if.sv
// Status/control bundle between the PLL supervisor and its surroundings.
//   pll_locked  : PLL LOCKED, asynchronous to the supervisor clock
//   clear_fault : single-cycle pulse, leaves FAULT and clears lock_lost
//   pll_reset   : PLL reset, active-high
//   rst_out     : per-domain resets, active-high, bit 0 released first
//   ready       : lock qualified and all domains out of reset
//   lock_lost   : sticky, lock dropped after qualification
//   fault       : retries exhausted
//   retry_count : timeouts in the current acquisition
// master = supervisor side, slave = consumer side.
interface pll_rst_seq_if
    import pll_rst_pkg::*;
#(
    parameter int unsigned NUM_DOMAINS = DEF_NUM_DOMAINS
);
    logic                   pll_locked;
    logic                   clear_fault;
    logic                   pll_reset;
    logic [NUM_DOMAINS-1:0] rst_out;
    logic                   ready;
    logic                   lock_lost;
    logic                   fault;
    logic [RETRY_W-1:0]     retry_count;

    modport master (
        input  pll_locked,
        input  clear_fault,
        output pll_reset,
        output rst_out,
        output ready,
        output lock_lost,
        output fault,
        output retry_count
    );

    modport slave (
        output pll_locked,
        output clear_fault,
        input  pll_reset,
        input  rst_out,
        input  ready,
        input  lock_lost,
        input  fault,
        input  retry_count
    );

endinterface

// File: rtl/bit_sync.sv
// Two-flop synchroniser for a single asynchronous status bit.
//   clk : destination clock
//   rst : asynchronous active-high reset, output resets to 0
//   d   : asynchronous input
//   q   : synchronised output, two clk cycles behind d
module bit_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_rst_seq.sv
// PLL supervisor and staggered reset sequencer, clocked from the board
// reference clock that feeds the PLL.
//   clk_in : reference clock
//   reset  : asynchronous active-high reset
//   bus    : pll_rst_seq_if.master (lock input, clear_fault, PLL reset,
//            per-domain resets and status flags)
module pll_rst_seq
    import pll_rst_pkg::*;
#(
    parameter int unsigned NUM_DOMAINS         = DEF_NUM_DOMAINS,
    parameter int unsigned RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int unsigned STAGE_DELAY_CYCLES  = DEF_STAGE_DELAY_CYCLES,
    parameter int unsigned MAX_RETRIES         = DEF_MAX_RETRIES
) (
    input  logic          clk_in,
    input  logic          reset,
    pll_rst_seq_if.master bus
);

    localparam int unsigned STAGE_SPAN = NUM_DOMAINS * STAGE_DELAY_CYCLES;
    localparam int unsigned CNT_MAX_A  = (RST_PULSE_CYCLES > LOCK_STABLE_CYCLES) ?
                                         RST_PULSE_CYCLES : LOCK_STABLE_CYCLES;
    localparam int unsigned CNT_MAX    = (CNT_MAX_A > STAGE_SPAN) ? CNT_MAX_A : STAGE_SPAN;
    localparam int unsigned CNT_W      = cnt_w(CNT_MAX);
    localparam int unsigned TMO_W      = cnt_w(LOCK_TIMEOUT_CYCLES - 1);

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(STAGE_SPAN);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT_CYCLES - 1);

    // A retry limit above what the counter can show can never be reached.
    localparam bit                 FAULT_EN = (MAX_RETRIES != 0) && (MAX_RETRIES <= RETRY_MAX);
    localparam logic [RETRY_W-1:0] MAX_R    = RETRY_W'(MAX_RETRIES);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [TMO_W-1:0]       tmo_q, tmo_d;
    logic                   pll_reset_q, pll_reset_d;
    logic [NUM_DOMAINS-1:0] rst_out_q, rst_out_d;
    logic                   ready_q, ready_d;
    logic                   lock_lost_q, lock_lost_d;
    logic                   fault_q, fault_d;
    logic [RETRY_W-1:0]     retry_q, retry_d;

    logic                   lk;
    logic                   tmo_hit;
    logic [RETRY_W-1:0]     retry_inc;
    logic                   timeout;
    logic                   loss;

    // Bring the PLL lock indication into the clk_in domain.
    bit_sync u_lock_sync (
        .clk (clk_in),
        .rst (reset),
        .d   (bus.pll_locked),
        .q   (lk)
    );

    // tmo holds at its terminal value so a late lk in WAIT_LOCK still times
    // out on the following STABLE cycle instead of wrapping.
    assign tmo_hit   = (tmo_q == TMO_LAST);
    assign retry_inc = (retry_q == RETRY_W'(RETRY_MAX)) ? retry_q : retry_q + RETRY_W'(1);

    // State and registered outputs.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q     <= RESET_PLL;
            cnt_q       <= '0;
            tmo_q       <= '0;
            pll_reset_q <= 1'b1;
            rst_out_q   <= '1;
            ready_q     <= 1'b0;
            lock_lost_q <= 1'b0;
            fault_q     <= 1'b0;
            retry_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            pll_reset_q <= pll_reset_d;
            rst_out_q   <= rst_out_d;
            ready_q     <= ready_d;
            lock_lost_q <= lock_lost_d;
            fault_q     <= fault_d;
            retry_q     <= retry_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;
        pll_reset_d = pll_reset_q;
        rst_out_d   = rst_out_q;
        ready_d     = ready_q;
        lock_lost_d = lock_lost_q;
        fault_d     = fault_q;
        retry_d     = retry_q;
        timeout     = 1'b0;
        loss        = 1'b0;

        case (state_q)
            RESET_PLL: begin
                pll_reset_d = 1'b1;
                if (cnt_q == RST_LAST) begin
                    state_d     = WAIT_LOCK;
                    pll_reset_d = 1'b0;
                    cnt_d       = '0;
                    tmo_d       = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            WAIT_LOCK: begin
                if (!tmo_hit) begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
                if (lk) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (tmo_hit) begin
                    timeout = 1'b1;
                end
            end

            // Stable terminal beats a coincident timeout.
            STABLE: begin
                if (lk && (cnt_q == STB_LAST)) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                    tmo_d   = '0;
                end else if (tmo_hit) begin
                    timeout = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                    if (lk) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end
                end
            end

            // Bits clear at strictly increasing counts, so release is in order.
            RELEASE: begin
                if (!lk) begin
                    loss = 1'b1;
                end else if (cnt_q == REL_LAST) begin
                    state_d = RUN;
                    ready_d = 1'b1;
                    retry_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    for (int unsigned i = 0; i < NUM_DOMAINS; i++) begin
                        if (cnt_q == CNT_W'(STAGE_DELAY_CYCLES * (i + 1) - 1)) begin
                            rst_out_d[i] = 1'b0;
                        end
                    end
                end
            end

            RUN: begin
                if (!lk) begin
                    loss = 1'b1;
                end
            end

            FAULT: begin
                pll_reset_d = 1'b1;
                rst_out_d   = '1;
                ready_d     = 1'b0;
                fault_d     = 1'b1;
                if (bus.clear_fault) begin
                    state_d = RESET_PLL;
                    fault_d = 1'b0;
                    retry_d = '0;
                    cnt_d   = '0;
                end
            end

            default: begin
                state_d     = RESET_PLL;
                pll_reset_d = 1'b1;
                cnt_d       = '0;
            end
        endcase

        // Lock timeout: count it, then retry or give up.
        if (timeout) begin
            retry_d     = retry_inc;
            cnt_d       = '0;
            pll_reset_d = 1'b1;
            if (FAULT_EN && (retry_inc == MAX_R)) begin
                state_d = FAULT;
                fault_d = 1'b1;
            end else begin
                state_d = RESET_PLL;
            end
        end

        // Lock dropped after qualification: slam every domain back into reset.
        if (loss) begin
            state_d     = RESET_PLL;
            cnt_d       = '0;
            pll_reset_d = 1'b1;
            rst_out_d   = '1;
            ready_d     = 1'b0;
        end

        // Setting lock_lost wins over a coincident clear.
        if (loss) begin
            lock_lost_d = 1'b1;
        end else if (bus.clear_fault) begin
            lock_lost_d = 1'b0;
        end
    end

    assign bus.pll_reset   = pll_reset_q;
    assign bus.rst_out     = rst_out_q;
    assign bus.ready       = ready_q;
    assign bus.lock_lost   = lock_lost_q;
    assign bus.fault       = fault_q;
    assign bus.retry_count = retry_q;

endmodule

// File: tb/tb_pll_rst_seq.sv
// Testbench for pll_rst_seq. Each scenario pushes the expected output
// changes (cycle and value) into a queue; a negedge monitor pops one entry
// every time the DUT's output vector changes and compares.
module tb_pll_rst_seq;

    localparam int unsigned N = 3;
    localparam int P = 4;
    localparam int T = 50;
    localparam int S = 8;
    localparam int D = 5;
    localparam int M = 2;

    typedef struct {
        int          cyc;
        logic [10:0] vec;
        string       tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   w_base = 0;
    exp_t exp_q[$];
    logic [10:0] prev = 'x;
    logic [10:0] cur;

    pll_rst_seq_if #(.NUM_DOMAINS(N)) bus ();

    pll_rst_seq #(
        .NUM_DOMAINS         (N),
        .RST_PULSE_CYCLES    (P),
        .LOCK_TIMEOUT_CYCLES (T),
        .LOCK_STABLE_CYCLES  (S),
        .STAGE_DELAY_CYCLES  (D),
        .MAX_RETRIES         (M)
    ) dut (
        .clk_in (clk),
        .reset  (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Vector layout: {pll_reset, rst_out[2:0], ready, lock_lost, fault, retry_count[3:0]}
    function automatic logic [10:0] mk(input logic pr, input logic [2:0] ro, input logic rdy,
                                       input logic ll, input logic f, input logic [3:0] rc);
        return {pr, ro, rdy, ll, f, rc};
    endfunction

    localparam logic [10:0] RST_VEC = {1'b1, 3'b111, 1'b0, 1'b0, 1'b0, 4'd0};

    // Monitor: every change of the output vector must match the next expectation.
    always @(negedge clk) begin
        exp_t e;
        cur = {bus.pll_reset, bus.rst_out, bus.ready, bus.lock_lost, bus.fault, bus.retry_count};
        if (cur !== prev) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_change: cycle %0d got %b, required no change", cyc, cur);
            end else begin
                e = exp_q.pop_front();
                if ((e.cyc != cyc) || (e.vec !== cur)) begin
                    miscompares++;
                    $display("FAIL %s: got cycle %0d vec %b, required cycle %0d vec %b",
                             e.tag, cyc, cur, e.cyc, e.vec);
                end
            end
        end
        prev = cur;
    end

    task automatic push(input int c, input logic [10:0] v, input string tag);
        exp_t e;
        e.cyc = c;
        e.vec = v;
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_drain(input string name);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_drain: %0d expected changes never seen (next %s @%0d), required 0",
                     name, exp_q.size(), exp_q[0].tag, exp_q[0].cyc);
            exp_q.delete();
        end
    endtask

    // Called #1 after a clock edge; reset takes effect before the next edge.
    task automatic do_reset();
        push(cyc, RST_VEC, "reset_values");
        rst             = 1'b1;
        bus.pll_locked  = 1'b0;
        bus.clear_fault = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        w_base = cyc + P;
    endtask

    // Lock rises 10 cycles after pll_reset falls and stays up.
    task automatic bring_up(input string name);
        int l;
        int e;
        l = w_base + 10;
        e = l + 3 + S;
        push(w_base,        mk(1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 4'd0), {name, "_pll_reset_fall"});
        push(e + D,         mk(1'b0, 3'b110, 1'b0, 1'b0, 1'b0, 4'd0), {name, "_rst0"});
        push(e + 2 * D,     mk(1'b0, 3'b100, 1'b0, 1'b0, 1'b0, 4'd0), {name, "_rst1"});
        push(e + 3 * D,     mk(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 4'd0), {name, "_rst2"});
        push(e + 3 * D + 1, mk(1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 4'd0), {name, "_ready"});
        wait_cyc(l);
        bus.pll_locked = 1'b1;
        wait_cyc(e + 3 * D + 5);
    endtask

    initial begin
        int w2;
        int e;
        int c;
        int x;
        int l;

        bus.pll_locked  = 1'b0;
        bus.clear_fault = 1'b0;
        @(posedge clk);
        #1;

        // Clean bring-up.
        do_reset();
        bring_up("clean");
        check_drain("clean");

        // Single timeout, then lock.
        do_reset();
        w2 = w_base + T + P;
        e  = w2 + 1 + S;
        push(w_base,        mk(1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 4'd0), "to_pll_reset_fall");
        push(w_base + T,    mk(1'b1, 3'b111, 1'b0, 1'b0, 1'b0, 4'd1), "to_timeout");
        push(w2,            mk(1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 4'd1), "to_pll_reset_fall2");
        push(e + D,         mk(1'b0, 3'b110, 1'b0, 1'b0, 1'b0, 4'd1), "to_rst0");
        push(e + 2 * D,     mk(1'b0, 3'b100, 1'b0, 1'b0, 1'b0, 4'd1), "to_rst1");
        push(e + 3 * D,     mk(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 4'd1), "to_rst2");
        push(e + 3 * D + 1, mk(1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 4'd0), "to_ready");
        wait_cyc(w_base + T);
        bus.pll_locked = 1'b1;
        wait_cyc(e + 3 * D + 4);
        check_drain("timeout");

        // Fault after two timeouts, then clear_fault.
        do_reset();
        w2 = w_base + T + P;
        c  = w2 + T + 10;
        push(w_base,     mk(1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 4'd0), "fault_pll_reset_fall");
        push(w_base + T, mk(1'b1, 3'b111, 1'b0, 1'b0, 1'b0, 4'd1), "fault_timeout1");
        push(w2,         mk(1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 4'd1), "fault_pll_reset_fall2");
        push(w2 + T,     mk(1'b1, 3'b111, 1'b0, 1'b0, 1'b1, 4'd2), "fault_enter");
        push(c + 1,      mk(1'b1, 3'b111, 1'b0, 1'b0, 1'b0, 4'd0), "fault_clear");
        push(c + 1 + P,  mk(1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 4'd0), "fault_new_pulse_end");
        wait_cyc(c);
        bus.clear_fault = 1'b1;
        wait_cyc(c + 1);
        bus.clear_fault = 1'b0;
        wait_cyc(c + 1 + P + 3);
        check_drain("fault");

        // Chattering lock: never qualifies, times out on schedule.
        do_reset();
        push(w_base,         mk(1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 4'd0), "chat_pll_reset_fall");
        push(w_base + T,     mk(1'b1, 3'b111, 1'b0, 1'b0, 1'b0, 4'd1), "chat_timeout");
        push(w_base + T + P, mk(1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 4'd1), "chat_pll_reset_fall2");
        l = w_base;
        for (int k = 0; k < 10; k++) begin
            wait_cyc(l + 5 * k);
            bus.pll_locked = ((k % 2) == 0);
        end
        wait_cyc(l + T);
        bus.pll_locked = 1'b0;
        wait_cyc(l + T + P + 2);
        check_drain("chatter");

        // Loss of lock in RUN, full re-acquire, then clear_fault drops lock_lost.
        do_reset();
        bring_up("loss_first");
        x  = cyc;
        w2 = x + 3 + P;
        e  = w2 + 1 + S;
        push(x + 3,         mk(1'b1, 3'b111, 1'b0, 1'b1, 1'b0, 4'd0), "loss_detect");
        push(w2,            mk(1'b0, 3'b111, 1'b0, 1'b1, 1'b0, 4'd0), "loss_pll_reset_fall");
        push(e + D,         mk(1'b0, 3'b110, 1'b0, 1'b1, 1'b0, 4'd0), "loss_rst0");
        push(e + 2 * D,     mk(1'b0, 3'b100, 1'b0, 1'b1, 1'b0, 4'd0), "loss_rst1");
        push(e + 3 * D,     mk(1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 4'd0), "loss_rst2");
        push(e + 3 * D + 1, mk(1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 4'd0), "loss_ready");
        push(e + 3 * D + 5, mk(1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 4'd0), "loss_clear_flag");
        bus.pll_locked = 1'b0;
        wait_cyc(x + 1);
        bus.pll_locked = 1'b1;
        wait_cyc(e + 3 * D + 4);
        bus.clear_fault = 1'b1;
        wait_cyc(e + 3 * D + 5);
        bus.clear_fault = 1'b0;
        wait_cyc(e + 3 * D + 8);
        check_drain("loss");

        // Async reset mid-RELEASE after rst_out[0] fell, then a normal restart.
        do_reset();
        l = w_base + 10;
        e = l + 3 + S;
        push(w_base, mk(1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 4'd0), "mid_pll_reset_fall");
        push(e + D,  mk(1'b0, 3'b110, 1'b0, 1'b0, 1'b0, 4'd0), "mid_rst0");
        wait_cyc(l);
        bus.pll_locked = 1'b1;
        wait_cyc(e + D + 2);
        do_reset();
        bring_up("restart");
        check_drain("restart");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Bound on total run time.
    initial begin
        #200000;
        miscompares++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d, required completion", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
